// File: rtl/mult_pipe.sv
// Five-stage pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) with flush,
// RAW-hazard detection against in-flight destinations, and a busy flag.
module mult_pipe (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        mul_valid_i,
    input  logic [2:0]  mul_funct3_i,
    input  logic [31:0] mul_op_a_i,
    input  logic [31:0] mul_op_b_i,
    input  logic [4:0]  mul_write_addr_i,
    input  logic [31:0] mul_instruction_i,
    input  logic [31:0] mul_pc_i,
    input  logic        flush_i,
    input  logic [4:0]  hz_rs1_i,
    input  logic [4:0]  hz_rs2_i,
    output logic [31:0] mult5_int_write_data_o,
    output logic [4:0]  mult5_write_addr_o,
    output logic        mult5_int_write_enable_o,
    output logic [31:0] mult5_instruction_o,
    output logic [31:0] mult5_pc_o,
    output logic        mult_hazard_o,
    output logic        mult_busy_o
);

    localparam logic [2:0] F3Mulh   = 3'b001;
    localparam logic [2:0] F3Mulhsu = 3'b010;
    localparam logic [2:0] F3Mulhu  = 3'b011;

    // Sideband state per stage.
    logic        m1_valid_q, m2_valid_q, m3_valid_q, m4_valid_q, m5_valid_q;
    logic [4:0]  m1_rd_q, m2_rd_q, m3_rd_q, m4_rd_q, m5_rd_q;
    logic [31:0] m1_instr_q, m2_instr_q, m3_instr_q, m4_instr_q, m5_instr_q;
    logic [31:0] m1_pc_q, m2_pc_q, m3_pc_q, m4_pc_q, m5_pc_q;
    logic [2:0]  m1_f3_q, m2_f3_q, m3_f3_q, m4_f3_q;

    // Arithmetic state per stage.
    logic [32:0] m1_a_q, m1_b_q;
    logic [33:0] m2_ll_q, m2_lh_q, m2_hl_q, m2_hh_q;
    logic [33:0] m3_ll_q, m3_hh_q;
    logic [34:0] m3_cross_q;
    logic [63:0] m4_prod_q;
    logic [31:0] m5_data_q;

    logic        a_signed, b_signed;
    logic [32:0] a_ext, b_ext;

    always_comb begin
        a_signed = (mul_funct3_i == F3Mulh) || (mul_funct3_i == F3Mulhsu);
        b_signed = (mul_funct3_i == F3Mulh);
        a_ext    = {a_signed & mul_op_a_i[31], mul_op_a_i};
        b_ext    = {b_signed & mul_op_b_i[31], mul_op_b_i};
    end

    // 33x33 split into 17-bit halves; low halves are unsigned, high halves carry the sign.
    // Operands are pre-extended to 34 bits so a plain 34-bit product is exact two's complement.
    logic [33:0] al_x, ah_x, bl_x, bh_x;

    always_comb begin
        al_x = {18'b0, m1_a_q[15:0]};
        bl_x = {18'b0, m1_b_q[15:0]};
        ah_x = {{17{m1_a_q[32]}}, m1_a_q[32:16]};
        bh_x = {{17{m1_b_q[32]}}, m1_b_q[32:16]};
    end

    logic [63:0] ll_x, cross_x, hh_x, prod_sum;

    always_comb begin
        ll_x     = {{30{m3_ll_q[33]}}, m3_ll_q};
        cross_x  = {{29{m3_cross_q[34]}}, m3_cross_q} << 16;
        hh_x     = {{30{m3_hh_q[33]}}, m3_hh_q} << 32;
        prod_sum = hh_x + cross_x + ll_x;
    end

    logic m4_is_high;

    always_comb begin
        m4_is_high = (m4_f3_q == F3Mulh) || (m4_f3_q == F3Mulhsu) || (m4_f3_q == F3Mulhu);
    end

    // M1: capture from issue.
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            m1_valid_q <= 1'b0;
            m1_rd_q    <= '0;
            m1_instr_q <= '0;
            m1_pc_q    <= '0;
            m1_f3_q    <= '0;
            m1_a_q     <= '0;
            m1_b_q     <= '0;
        end else begin
            m1_valid_q <= mul_valid_i && !flush_i;
            if (mul_valid_i && !flush_i) begin
                m1_rd_q    <= mul_write_addr_i;
                m1_instr_q <= mul_instruction_i;
                m1_pc_q    <= mul_pc_i;
                m1_f3_q    <= mul_funct3_i;
                m1_a_q     <= a_ext;
                m1_b_q     <= b_ext;
            end
        end
    end

    // M2: four partial products.
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            m2_valid_q <= 1'b0;
            m2_rd_q    <= '0;
            m2_instr_q <= '0;
            m2_pc_q    <= '0;
            m2_f3_q    <= '0;
            m2_ll_q    <= '0;
            m2_lh_q    <= '0;
            m2_hl_q    <= '0;
            m2_hh_q    <= '0;
        end else begin
            m2_valid_q <= m1_valid_q && !flush_i;
            m2_rd_q    <= m1_rd_q;
            m2_instr_q <= m1_instr_q;
            m2_pc_q    <= m1_pc_q;
            m2_f3_q    <= m1_f3_q;
            m2_ll_q    <= al_x * bl_x;
            m2_lh_q    <= al_x * bh_x;
            m2_hl_q    <= ah_x * bl_x;
            m2_hh_q    <= ah_x * bh_x;
        end
    end

    // M3: merge the two cross terms.
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            m3_valid_q <= 1'b0;
            m3_rd_q    <= '0;
            m3_instr_q <= '0;
            m3_pc_q    <= '0;
            m3_f3_q    <= '0;
            m3_ll_q    <= '0;
            m3_hh_q    <= '0;
            m3_cross_q <= '0;
        end else begin
            m3_valid_q <= m2_valid_q && !flush_i;
            m3_rd_q    <= m2_rd_q;
            m3_instr_q <= m2_instr_q;
            m3_pc_q    <= m2_pc_q;
            m3_f3_q    <= m2_f3_q;
            m3_ll_q    <= m2_ll_q;
            m3_hh_q    <= m2_hh_q;
            m3_cross_q <= {m2_lh_q[33], m2_lh_q} + {m2_hl_q[33], m2_hl_q};
        end
    end

    // M4: full 64-bit product.
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            m4_valid_q <= 1'b0;
            m4_rd_q    <= '0;
            m4_instr_q <= '0;
            m4_pc_q    <= '0;
            m4_f3_q    <= '0;
            m4_prod_q  <= '0;
        end else begin
            m4_valid_q <= m3_valid_q && !flush_i;
            m4_rd_q    <= m3_rd_q;
            m4_instr_q <= m3_instr_q;
            m4_pc_q    <= m3_pc_q;
            m4_f3_q    <= m3_f3_q;
            m4_prod_q  <= prod_sum;
        end
    end

    // M5: result select; payload only updates for a live entry so it holds otherwise.
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            m5_valid_q <= 1'b0;
            m5_rd_q    <= '0;
            m5_instr_q <= '0;
            m5_pc_q    <= '0;
            m5_data_q  <= '0;
        end else begin
            m5_valid_q <= m4_valid_q && !flush_i;
            if (m4_valid_q && !flush_i) begin
                m5_rd_q    <= m4_rd_q;
                m5_instr_q <= m4_instr_q;
                m5_pc_q    <= m4_pc_q;
                m5_data_q  <= m4_is_high ? m4_prod_q[63:32] : m4_prod_q[31:0];
            end
        end
    end

    function automatic logic stage_hit(input logic v, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return v && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

    always_comb begin
        mult_hazard_o = stage_hit(m1_valid_q, m1_rd_q, hz_rs1_i, hz_rs2_i) ||
                        stage_hit(m2_valid_q, m2_rd_q, hz_rs1_i, hz_rs2_i) ||
                        stage_hit(m3_valid_q, m3_rd_q, hz_rs1_i, hz_rs2_i) ||
                        stage_hit(m4_valid_q, m4_rd_q, hz_rs1_i, hz_rs2_i) ||
                        stage_hit(m5_valid_q, m5_rd_q, hz_rs1_i, hz_rs2_i);
        mult_busy_o   = m1_valid_q || m2_valid_q || m3_valid_q || m4_valid_q || m5_valid_q;
    end

    assign mult5_int_write_data_o   = m5_data_q;
    assign mult5_write_addr_o       = m5_rd_q;
    assign mult5_int_write_enable_o = m5_valid_q && (m5_rd_q != 5'd0);
    assign mult5_instruction_o      = m5_instr_q;
    assign mult5_pc_o               = m5_pc_q;

endmodule

// File: tb/tb_mult_pipe.sv
// Directed self-checking bench for mult_pipe: latency, signedness variants,
// back-to-back throughput, rd=0, hazard, flush and asynchronous reset.
module tb_mult_pipe;

    logic        clk_i = 1'b0;
    logic        rsn_i = 1'b0;
    logic        mul_valid_i = 1'b0;
    logic [2:0]  mul_funct3_i = '0;
    logic [31:0] mul_op_a_i = '0;
    logic [31:0] mul_op_b_i = '0;
    logic [4:0]  mul_write_addr_i = '0;
    logic [31:0] mul_instruction_i = '0;
    logic [31:0] mul_pc_i = '0;
    logic        flush_i = 1'b0;
    logic [4:0]  hz_rs1_i = '0;
    logic [4:0]  hz_rs2_i = '0;
    logic [31:0] mult5_int_write_data_o;
    logic [4:0]  mult5_write_addr_o;
    logic        mult5_int_write_enable_o;
    logic [31:0] mult5_instruction_o;
    logic [31:0] mult5_pc_o;
    logic        mult_hazard_o;
    logic        mult_busy_o;

    int n_cmp = 0;
    int n_err = 0;

    mult_pipe dut (
        .clk_i                    (clk_i),
        .rsn_i                    (rsn_i),
        .mul_valid_i              (mul_valid_i),
        .mul_funct3_i             (mul_funct3_i),
        .mul_op_a_i               (mul_op_a_i),
        .mul_op_b_i               (mul_op_b_i),
        .mul_write_addr_i         (mul_write_addr_i),
        .mul_instruction_i        (mul_instruction_i),
        .mul_pc_i                 (mul_pc_i),
        .flush_i                  (flush_i),
        .hz_rs1_i                 (hz_rs1_i),
        .hz_rs2_i                 (hz_rs2_i),
        .mult5_int_write_data_o   (mult5_int_write_data_o),
        .mult5_write_addr_o       (mult5_write_addr_o),
        .mult5_int_write_enable_o (mult5_int_write_enable_o),
        .mult5_instruction_o      (mult5_instruction_o),
        .mult5_pc_o               (mult5_pc_o),
        .mult_hazard_o            (mult_hazard_o),
        .mult_busy_o              (mult_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] ins);
        mul_valid_i       = 1'b1;
        mul_funct3_i      = f3;
        mul_op_a_i        = a;
        mul_op_b_i        = b;
        mul_write_addr_i  = rd;
        mul_pc_i          = pc;
        mul_instruction_i = ins;
    endtask

    task automatic idle();
        mul_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #1 rsn_i = 1'b1;
        tick();
        tick();
        n_cmp += 7;
        if (mult5_int_write_data_o !== 32'h0) begin
            n_err++; $display("FAIL reset_data got %h want 00000000", mult5_int_write_data_o);
        end
        if (mult5_write_addr_o !== 5'd0) begin
            n_err++; $display("FAIL reset_addr got %0d want 0", mult5_write_addr_o);
        end
        if (mult5_int_write_enable_o !== 1'b0) begin
            n_err++; $display("FAIL reset_en got %b want 0", mult5_int_write_enable_o);
        end
        if (mult5_instruction_o !== 32'h0) begin
            n_err++; $display("FAIL reset_instr got %h want 00000000", mult5_instruction_o);
        end
        if (mult5_pc_o !== 32'h0) begin
            n_err++; $display("FAIL reset_pc got %h want 00000000", mult5_pc_o);
        end
        if (mult_hazard_o !== 1'b0) begin
            n_err++; $display("FAIL reset_hazard got %b want 0", mult_hazard_o);
        end
        if (mult_busy_o !== 1'b0) begin
            n_err++; $display("FAIL reset_busy got %b want 0", mult_busy_o);
        end
        rsn_i = 1'b0;
    endtask

    task automatic test_mul_basic();
        issue(3'b000, 32'd7, 32'd6, 5'd5, 32'h100, 32'h026302B3);
        tick();
        idle();
        n_cmp++;
        if (mult_busy_o !== 1'b1) begin
            n_err++; $display("FAIL basic_busy got %b want 1", mult_busy_o);
        end
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_cmp++;
            if (mult5_int_write_enable_o !== 1'b0) begin
                n_err++; $display("FAIL basic_early_en edge %0d got %b want 0", e,
                                  mult5_int_write_enable_o);
            end
        end
        tick();
        n_cmp += 5;
        if (mult5_int_write_enable_o !== 1'b1) begin
            n_err++; $display("FAIL basic_en got %b want 1", mult5_int_write_enable_o);
        end
        if (mult5_int_write_data_o !== 32'h0000002A) begin
            n_err++; $display("FAIL basic_data got %h want 0000002a", mult5_int_write_data_o);
        end
        if (mult5_write_addr_o !== 5'd5) begin
            n_err++; $display("FAIL basic_addr got %0d want 5", mult5_write_addr_o);
        end
        if (mult5_pc_o !== 32'h100) begin
            n_err++; $display("FAIL basic_pc got %h want 00000100", mult5_pc_o);
        end
        if (mult5_instruction_o !== 32'h026302B3) begin
            n_err++; $display("FAIL basic_instr got %h want 026302b3", mult5_instruction_o);
        end
        tick();
        n_cmp++;
        if (mult5_int_write_enable_o !== 1'b0) begin
            n_err++; $display("FAIL basic_en_drop got %b want 0", mult5_int_write_enable_o);
        end
    endtask

    // Issue a table of ops on consecutive edges; results must emerge on consecutive cycles.
    task automatic run_stream(input string name, input int n, input logic [2:0] f3[10],
                              input logic [31:0] a[10], input logic [31:0] b[10],
                              input logic [31:0] exp[10]);
        for (int i = 0; i < n + 4; i++) begin
            if (i < n) issue(f3[i], a[i], b[i], 5'(i + 1), 32'h200 + 32'(4 * i), 32'hA000 + 32'(i));
            else idle();
            tick();
            if (i >= 4) begin
                n_cmp += 3;
                if (mult5_int_write_enable_o !== 1'b1) begin
                    n_err++; $display("FAIL %s_en[%0d] got %b want 1", name, i - 4,
                                      mult5_int_write_enable_o);
                end
                if (mult5_int_write_data_o !== exp[i-4]) begin
                    n_err++; $display("FAIL %s_data[%0d] got %h want %h", name, i - 4,
                                      mult5_int_write_data_o, exp[i-4]);
                end
                if (mult5_write_addr_o !== 5'(i - 3)) begin
                    n_err++; $display("FAIL %s_addr[%0d] got %0d want %0d", name, i - 4,
                                      mult5_write_addr_o, i - 3);
                end
            end
        end
        idle();
        tick();
        n_cmp++;
        if (mult5_int_write_enable_o !== 1'b0) begin
            n_err++; $display("FAIL %s_tail_en got %b want 0", name, mult5_int_write_enable_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3[10];
        logic [31:0] a[10], b[10], exp[10];
        f3[0] = 3'b001; a[0] = 32'hFFFFFFFF; b[0] = 32'hFFFFFFFF; exp[0] = 32'h00000000;
        f3[1] = 3'b011; a[1] = 32'hFFFFFFFF; b[1] = 32'hFFFFFFFF; exp[1] = 32'hFFFFFFFE;
        f3[2] = 3'b010; a[2] = 32'hFFFFFFFF; b[2] = 32'hFFFFFFFF; exp[2] = 32'hFFFFFFFF;
        f3[3] = 3'b000; a[3] = 32'h80000000; b[3] = 32'd2;        exp[3] = 32'h00000000;
        for (int i = 4; i < 10; i++) begin
            f3[i] = '0; a[i] = '0; b[i] = '0; exp[i] = '0;
        end
        run_stream("b2b", 4, f3, a, b, exp);
    endtask

    task automatic test_signedness();
        logic [2:0]  f3[10];
        logic [31:0] a[10], b[10], exp[10];
        f3[0] = 3'b001; a[0] = 32'hFFFFFFFE; b[0] = 32'd3;        exp[0] = 32'hFFFFFFFF;
        f3[1] = 3'b010; a[1] = 32'h80000000; b[1] = 32'h80000000; exp[1] = 32'hC0000000;
        f3[2] = 3'b011; a[2] = 32'h80000000; b[2] = 32'h80000000; exp[2] = 32'h40000000;
        f3[3] = 3'b001; a[3] = 32'h80000000; b[3] = 32'h80000000; exp[3] = 32'h40000000;
        f3[4] = 3'b011; a[4] = 32'h12345678; b[4] = 32'h00010000; exp[4] = 32'h00001234;
        f3[5] = 3'b000; a[5] = 32'h0001FFFF; b[5] = 32'h00010001; exp[5] = 32'h0000FFFF;
        f3[6] = 3'b011; a[6] = 32'h0001FFFF; b[6] = 32'h00010001; exp[6] = 32'h00000002;
        f3[7] = 3'b111; a[7] = 32'd7;        b[7] = 32'd6;        exp[7] = 32'h0000002A;
        f3[8] = 3'b000; a[8] = 32'hFFFFFFFD; b[8] = 32'd5;        exp[8] = 32'hFFFFFFF1;
        f3[9] = 3'b001; a[9] = 32'h7FFFFFFF; b[9] = 32'h7FFFFFFF; exp[9] = 32'h3FFFFFFF;
        run_stream("sign", 10, f3, a, b, exp);
    endtask

    task automatic test_rd_zero();
        hz_rs1_i = 5'd0;
        hz_rs2_i = 5'd0;
        issue(3'b000, 32'd3, 32'd3, 5'd0, 32'h300, 32'h02318033);
        for (int e = 0; e <= 4; e++) begin
            tick();
            idle();
            n_cmp++;
            if (mult_hazard_o !== 1'b0) begin
                n_err++; $display("FAIL rd0_hazard edge %0d got %b want 0", e, mult_hazard_o);
            end
        end
        n_cmp++;
        if (mult5_int_write_enable_o !== 1'b0) begin
            n_err++; $display("FAIL rd0_en got %b want 0", mult5_int_write_enable_o);
        end
        tick();
    endtask

    task automatic test_hazard();
        hz_rs1_i = 5'd3;
        hz_rs2_i = 5'd9;
        n_cmp++;
        if (mult_hazard_o !== 1'b0) begin
            n_err++; $display("FAIL hz_idle got %b want 0", mult_hazard_o);
        end
        issue(3'b000, 32'd4, 32'd5, 5'd9, 32'h400, 32'h025404B3);
        for (int e = 0; e <= 5; e++) begin
            tick();
            idle();
            n_cmp++;
            if (mult_hazard_o !== (e <= 4)) begin
                n_err++; $display("FAIL hz_track edge %0d got %b want %b", e, mult_hazard_o,
                                  e <= 4);
            end
        end
        // Same op again, killed by a flush at its third edge.
        issue(3'b000, 32'd4, 32'd5, 5'd9, 32'h404, 32'h025404B3);
        tick();
        idle();
        tick();
        flush_i = 1'b1;
        n_cmp++;
        if (mult_hazard_o !== 1'b1) begin
            n_err++; $display("FAIL hz_during_flush got %b want 1", mult_hazard_o);
        end
        tick();
        flush_i = 1'b0;
        n_cmp += 2;
        if (mult_hazard_o !== 1'b0) begin
            n_err++; $display("FAIL hz_after_flush got %b want 0", mult_hazard_o);
        end
        if (mult_busy_o !== 1'b0) begin
            n_err++; $display("FAIL flush_busy got %b want 0", mult_busy_o);
        end
        for (int e = 3; e <= 6; e++) begin
            tick();
            n_cmp++;
            if (mult5_int_write_enable_o !== 1'b0) begin
                n_err++; $display("FAIL flush_en edge %0d got %b want 0", e,
                                  mult5_int_write_enable_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        hz_rs1_i = 5'd1;
        hz_rs2_i = 5'd2;
        for (int i = 0; i < 3; i++) begin
            issue(3'b000, 32'd10 + 32'(i), 32'd3, 5'(i + 1), 32'h500 + 32'(4 * i), 32'hB000);
            tick();
        end
        idle();
        #2 rsn_i = 1'b1;
        #1;
        n_cmp += 7;
        if (mult5_int_write_data_o !== 32'h0) begin
            n_err++; $display("FAIL rstmid_data got %h want 00000000", mult5_int_write_data_o);
        end
        if (mult5_write_addr_o !== 5'd0) begin
            n_err++; $display("FAIL rstmid_addr got %0d want 0", mult5_write_addr_o);
        end
        if (mult5_int_write_enable_o !== 1'b0) begin
            n_err++; $display("FAIL rstmid_en got %b want 0", mult5_int_write_enable_o);
        end
        if (mult5_instruction_o !== 32'h0) begin
            n_err++; $display("FAIL rstmid_instr got %h want 00000000", mult5_instruction_o);
        end
        if (mult5_pc_o !== 32'h0) begin
            n_err++; $display("FAIL rstmid_pc got %h want 00000000", mult5_pc_o);
        end
        if (mult_hazard_o !== 1'b0) begin
            n_err++; $display("FAIL rstmid_hazard got %b want 0", mult_hazard_o);
        end
        if (mult_busy_o !== 1'b0) begin
            n_err++; $display("FAIL rstmid_busy got %b want 0", mult_busy_o);
        end
        tick();
        rsn_i = 1'b0;
        issue(3'b000, 32'd2, 32'd3, 5'd4, 32'h600, 32'h02310233);
        for (int e = 0; e <= 3; e++) begin
            tick();
            idle();
            n_cmp++;
            if (mult5_int_write_enable_o !== 1'b0) begin
                n_err++; $display("FAIL rstmid_ghost edge %0d got %b want 0", e,
                                  mult5_int_write_enable_o);
            end
        end
        tick();
        n_cmp += 3;
        if (mult5_int_write_enable_o !== 1'b1) begin
            n_err++; $display("FAIL rstmid_new_en got %b want 1", mult5_int_write_enable_o);
        end
        if (mult5_int_write_data_o !== 32'h00000006) begin
            n_err++; $display("FAIL rstmid_new_data got %h want 00000006",
                              mult5_int_write_data_o);
        end
        if (mult5_write_addr_o !== 5'd4) begin
            n_err++; $display("FAIL rstmid_new_addr got %0d want 4", mult5_write_addr_o);
        end
        tick();
    endtask

    task automatic test_valid_flush();
        issue(3'b000, 32'd5, 32'd5, 5'd7, 32'h700, 32'h025383B3);
        flush_i = 1'b1;
        tick();
        idle();
        flush_i = 1'b0;
        n_cmp++;
        if (mult_busy_o !== 1'b0) begin
            n_err++; $display("FAIL vflush_busy got %b want 0", mult_busy_o);
        end
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_cmp++;
            if (mult5_int_write_enable_o !== 1'b0) begin
                n_err++; $display("FAIL vflush_en edge %0d got %b want 0", e,
                                  mult5_int_write_enable_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_back_to_back();
        test_signedness();
        test_rd_zero();
        test_hazard();
        test_reset_mid();
        test_valid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Five-stage pipelined integer multiplier for the RV32M multiply group (MUL, MULH, MULHSU, MULHU). It accepts one multiply per cycle from decode/issue and delivers a result exactly five clock edges later on the mult5_* bundle consumed by the execute/write-back latch. It also exports a combinational RAW-hazard flag so issue can stall consumers of in-flight multiply results. Accepted entries can be killed by flush.

## Interface
Parameters:
- none; widths fixed at 32-bit data and 5-bit register address.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rsn_i  in  1  reset; asynchronous, active-high (1 = reset)
- mul_valid_i  in  1  issue a multiply this cycle
- mul_funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; other codes treated as MUL
- mul_op_a_i  in  32  rs1 value
- mul_op_b_i  in  32  rs2 value
- mul_write_addr_i  in  5  rd
- mul_instruction_i  in  32  instruction word, carried unchanged
- mul_pc_i  in  32  PC, carried unchanged
- flush_i  in  1  kill all in-flight and incoming entries
- hz_rs1_i, hz_rs2_i  in  5 each  source registers of the instruction in decode
- mult5_int_write_data_o  out  32  result
- mult5_write_addr_o  out  5  rd of result
- mult5_int_write_enable_o  out  1  result valid and rd != 0
- mult5_instruction_o  out  32  instruction of result
- mult5_pc_o  out  32  PC of result
- mult_hazard_o  out  1  hz_rs1_i or hz_rs2_i matches a pending rd
- mult_busy_o  out  1  any stage M1..M5 valid

## Operation
- Stages M1..M5 each hold: valid, rd, instruction, PC, funct3, and arithmetic state. M5 drives the mult5_* outputs directly from registers.
- Capture: at an edge with mul_valid_i=1 and flush_i=0, M1 loads the operands and sideband; M1.valid is set. Otherwise M1.valid is cleared. Each edge, Mk moves to Mk+1 unconditionally. There is no stall or backpressure, and the pipe never holds an entry.
- Operand extension to 33 bits: a is signed for MULH and MULHSU, otherwise zero-extended. b is signed for MULH only, otherwise zero-extended.
- Arithmetic: form the 66-bit two's-complement product of the 33-bit operands; only bits [63:0] are meaningful. MUL returns P[31:0]; MULH, MULHSU and MULHU return P[63:32]. How partial products are split across M1..M4 is free, but the M5 value must be exact.
- Write enable: mult5_int_write_enable_o = M5.valid && M5.rd != 0. When M5 is invalid, data, addr, instruction and PC hold their last values; consumers qualify them with the enable.
- Flush: at an edge with flush_i=1, the incoming entry is dropped and the valids of M1..M4 are cleared, so M2..M5 become invalid after that edge. The M5 contents visible during the flush cycle have already been presented and are not recalled.
- Hazard: mult_hazard_o = OR over k=1..5 of (Mk.valid && Mk.rd != 0 && (Mk.rd == hz_rs1_i || Mk.rd == hz_rs2_i)). It is purely combinational and not masked by flush_i.
- mult_busy_o = OR of Mk.valid, k=1..5.

## Timing
- Latency: an entry captured at edge t appears on mult5_* after edge t+4 (the 5th register), stable for the cycle following edge t+4.
- Throughput: 1 per cycle. Back-to-back issues emerge in order on consecutive cycles.
- Reset: asserting rsn_i clears all valids and zeroes every output register immediately, without waiting for a clock. While reset is asserted, all outputs are 0 (data, addr, enable, instruction, PC), and mult_hazard_o=0, mult_busy_o=0. Reset mid-operation discards all entries. The first capture occurs on the first edge after rsn_i deasserts.
- Simultaneous mul_valid_i and flush_i: flush wins and nothing is captured.

## Test plan
- MUL 7×6, rd=5, PC=0x100, issued at edge 0 -> enable=1, data=0x0000002A, addr=5, PC=0x100 after edge 4; enable=0 the following cycle.
- Issue four ops back-to-back: MULH 0xFFFFFFFF×0xFFFFFFFF, MULHU 0xFFFFFFFF×0xFFFFFFFF, MULHSU 0xFFFFFFFF×0xFFFFFFFF, MUL 0x80000000×2 -> results on 4 consecutive cycles: 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- rd=0 MUL 3×3 -> after edge 4, enable=0; mult_hazard_o stays 0 with hz_rs1_i=0 throughout.
- Issue MUL rd=9 at edge 0, hz_rs2_i=9 -> mult_hazard_o=1 in cycles after edges 0–4, 0 after edge 5. Assert flush_i at edge 2 -> enable never rises and hazard drops after edge 2.
- Three issues in flight, assert rsn_i between edges -> all outputs 0 immediately, mult_busy_o=0. After release, a new MUL 2×3 -> 0x00000006 after 5 edges, with no ghost results.
- mul_valid_i=1 together with flush_i=1 -> no output enable in the next 6 cycles.
